// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Holds the sequencer state enum, the bit positions of each stage inside the
// stall and flush vectors, and the bundled control word driven to the
// pipeline registers.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        REPLAY  = 2'd2,
        HALT    = 2'd3
    } seq_state_e;

    // Bit positions inside ctrl_t.stall (register enable = ~stall).
    localparam int STALL_F = 0;
    localparam int STALL_D = 1;
    localparam int STALL_E = 2;
    localparam int STALL_M = 3;

    // Bit positions inside ctrl_t.flush (synchronous clear).
    localparam int FLUSH_D = 0;
    localparam int FLUSH_E = 1;
    localparam int FLUSH_M = 2;
    localparam int FLUSH_W = 3;

    typedef struct packed {
        logic [3:0] stall;
        logic [3:0] flush;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE  = '{stall: 4'b0000, flush: 4'b0000};
    localparam ctrl_t CTRL_ALL   = '{stall: 4'b1111, flush: 4'b1111};
    localparam ctrl_t CTRL_RESET = '{stall: 4'b0000, flush: 4'b1111};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping; reset and clr both return it to 0.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    // Count up on inc, stop at all-ones, clear on reset or clr.
    // NOTE: state flops use non-blocking assignments so every flop samples the pre-edge value.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Control outputs are combinational from the registered state and the
// current hazard inputs so they reach the pipeline registers in the same
// cycle. A retry counter replays a faulting instruction up to RETRY_MAX
// times before trapping into HALT; a MEMWAIT timer turns a hung data access
// into a fault.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is
// defined; otherwise both counter ports are tied to zero.
module pipe_seq_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RETRY_MAX   = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load_use_i,
    input  logic                           branch_taken_i,
    input  logic                           mem_req_i,
    input  logic                           mem_ack_i,
    input  logic                           fault_i,
    input  logic                           retire_i,
    output logic                           stall_f,
    output logic                           stall_d,
    output logic                           stall_e,
    output logic                           stall_m,
    output logic                           flush_d,
    output logic                           flush_e,
    output logic                           flush_m,
    output logic                           flush_w,
    output logic                           replay_o,
    output logic                           trap_o,
    output logic                           busy_o,
    output logic [$clog2(RETRY_MAX+1)-1:0] retry_cnt_o,
    output logic [CNT_W-1:0]               stall_cycles_o,
    output logic [CNT_W-1:0]               flush_events_o
);

    localparam int RC_W  = $clog2(RETRY_MAX + 1);
    localparam int TMR_W = $clog2(MEM_TIMEOUT);

    seq_state_e       state, state_nxt;
    logic [RC_W-1:0]  retry_cnt, retry_nxt;
    logic [TMR_W-1:0] timer;
    logic             timeout;
    logic             fault_take;
    logic             replay, trap;
    ctrl_t            ctrl, ctrl_o;

    // Cycles spent in MEMWAIT; cleared in every other state so each wait starts at 0.
    sat_counter #(.WIDTH(TMR_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (state != MEMWAIT),
        .inc   (state == MEMWAIT),
        .q     (timer)
    );

    assign timeout = (timer == TMR_W'(MEM_TIMEOUT - 1));

    // Hazard resolution: next state, next retry count and this cycle's control word.
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        ctrl       = CTRL_NONE;
        state_nxt  = state;
        retry_nxt  = retry_cnt;
        replay     = 1'b0;
        trap       = 1'b0;
        fault_take = 1'b0;

        unique case (state)
            RUN: begin
                if (fault_i) begin
                    fault_take = 1'b1;
                end else if (mem_req_i && !mem_ack_i) begin
                    ctrl.stall          = '1;
                    ctrl.flush[FLUSH_W] = 1'b1;
                    state_nxt           = MEMWAIT;
                end else if (branch_taken_i) begin
                    // A taken branch squashes the wrong-path D/E slots and wins over load-use.
                    ctrl.flush[FLUSH_D] = 1'b1;
                    ctrl.flush[FLUSH_E] = 1'b1;
                end else if (load_use_i) begin
                    ctrl.stall[STALL_F] = 1'b1;
                    ctrl.stall[STALL_D] = 1'b1;
                    ctrl.flush[FLUSH_E] = 1'b1;
                end
            end
            MEMWAIT: begin
                if (fault_i || timeout) begin
                    fault_take = 1'b1;
                end else if (mem_ack_i) begin
                    state_nxt = RUN;
                end else begin
                    ctrl.stall          = '1;
                    ctrl.flush[FLUSH_W] = 1'b1;
                end
            end
            REPLAY: begin
                // Pipe is being refilled from the faulting PC; a fault here is stale.
                ctrl.flush[FLUSH_D] = 1'b1;
                ctrl.flush[FLUSH_E] = 1'b1;
                ctrl.flush[FLUSH_M] = 1'b1;
                state_nxt           = RUN;
            end
            HALT: begin
                ctrl = CTRL_ALL;
            end
        endcase

        if (fault_take) begin
            ctrl.flush = '1;
            if (retry_cnt < RC_W'(RETRY_MAX)) begin
                replay    = 1'b1;
                retry_nxt = retry_cnt + RC_W'(1);
                state_nxt = REPLAY;
            end else begin
                trap      = 1'b1;
                state_nxt = HALT;
            end
        end else if (retire_i && !fault_i && (state != HALT)) begin
            retry_nxt = '0;
        end
    end

    // Reset overrides the control word: clear every stage, hold nothing.
    always_comb begin
        ctrl_o   = reset ? CTRL_RESET : ctrl;
        replay_o = replay && !reset;
        trap_o   = trap && !reset;
        busy_o   = (state != RUN) && !reset;
    end

    // Sequencer state and retry count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            retry_cnt <= '0;
        end else begin
            state     <= state_nxt;
            retry_cnt <= retry_nxt;
        end
    end

    assign stall_f     = ctrl_o.stall[STALL_F];
    assign stall_d     = ctrl_o.stall[STALL_D];
    assign stall_e     = ctrl_o.stall[STALL_E];
    assign stall_m     = ctrl_o.stall[STALL_M];
    assign flush_d     = ctrl_o.flush[FLUSH_D];
    assign flush_e     = ctrl_o.flush[FLUSH_E];
    assign flush_m     = ctrl_o.flush[FLUSH_M];
    assign flush_w     = ctrl_o.flush[FLUSH_W];
    assign retry_cnt_o = retry_cnt;

`ifdef PIPE_PERF_CNT_EN
    // Cycles with any stage held.
    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (|ctrl_o.stall),
        .q     (stall_cycles_o)
    );

    // Cycles with any stage cleared, not counting reset.
    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   ((|ctrl_o.flush) && !reset),
        .q     (flush_events_o)
    );
`else
    assign stall_cycles_o = '0;
    assign flush_events_o = '0;
`endif

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Scoreboard bench for pipe_seq_ctrl.
// A driver applies one input vector per cycle, asks a behavioural model what
// the outputs must be in that cycle and queues the answer; a monitor on the
// falling edge pops each entry and compares it with the DUT. Mirrors
// PIPE_PERF_CNT_EN so the counter expectations follow the build.
module tb_pipe_seq_ctrl;

    localparam int RETRY_MAX   = 3;
    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;
    localparam int RC_W        = $clog2(RETRY_MAX + 1);
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             load_use_i = 1'b0, branch_taken_i = 1'b0, mem_req_i = 1'b0;
    logic             mem_ack_i = 1'b0, fault_i = 1'b0, retire_i = 1'b0;
    logic             stall_f, stall_d, stall_e, stall_m;
    logic             flush_d, flush_e, flush_m, flush_w;
    logic             replay_o, trap_o, busy_o;
    logic [RC_W-1:0]  retry_cnt_o;
    logic [CNT_W-1:0] stall_cycles_o, flush_events_o;

    pipe_seq_ctrl #(
        .RETRY_MAX   (RETRY_MAX),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .load_use_i     (load_use_i),
        .branch_taken_i (branch_taken_i),
        .mem_req_i      (mem_req_i),
        .mem_ack_i      (mem_ack_i),
        .fault_i        (fault_i),
        .retire_i       (retire_i),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .stall_e        (stall_e),
        .stall_m        (stall_m),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .flush_m        (flush_m),
        .flush_w        (flush_w),
        .replay_o       (replay_o),
        .trap_o         (trap_o),
        .busy_o         (busy_o),
        .retry_cnt_o    (retry_cnt_o),
        .stall_cycles_o (stall_cycles_o),
        .flush_events_o (flush_events_o)
    );

    always #5 clk = ~clk;

    // Expected outputs for one cycle. stall bits: {m,e,d,f}; flush bits: {w,m,e,d}.
    typedef struct {
        logic [3:0]  stall;
        logic [3:0]  flush;
        logic        replay;
        logic        trap;
        logic        busy;
        int          retry;
        int unsigned scnt;
        int unsigned fcnt;
        bit          known;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Behavioural model: plain flags and integer counters.
    bit          m_known   = 1'b0;
    bit          m_halted  = 1'b0;
    bit          m_waiting = 1'b0;
    bit          m_refill  = 1'b0;
    int          m_waited  = 0;
    int          m_retries = 0;
    int unsigned m_stalls  = 0;
    int unsigned m_flushes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit li, input bit bt, input bit mr,
                              input bit ma, input bit f, input bit rt, output exp_t e);
        bit fault_now;
        e.stall  = 4'b0000;
        e.flush  = 4'b0000;
        e.replay = 1'b0;
        e.trap   = 1'b0;
        e.busy   = !rst && (m_halted || m_waiting || m_refill);
        e.retry  = m_retries;
        e.scnt   = PERF_EN ? m_stalls : 0;
        e.fcnt   = PERF_EN ? m_flushes : 0;
        e.known  = m_known;
        if (rst) begin
            e.flush   = 4'b1111;
            m_known   = 1'b1;
            m_halted  = 1'b0;
            m_waiting = 1'b0;
            m_refill  = 1'b0;
            m_waited  = 0;
            m_retries = 0;
            m_stalls  = 0;
            m_flushes = 0;
            return;
        end
        if (m_halted) begin
            e.stall = 4'b1111;
            e.flush = 4'b1111;
        end else if (m_refill) begin
            e.flush  = 4'b0111;
            m_refill = 1'b0;
            if (rt && !f) m_retries = 0;
        end else begin
            fault_now = f || (m_waiting && (m_waited == MEM_TIMEOUT - 1));
            if (fault_now) begin
                e.flush   = 4'b1111;
                m_waiting = 1'b0;
                if (m_retries < RETRY_MAX) begin
                    e.replay  = 1'b1;
                    m_retries = m_retries + 1;
                    m_refill  = 1'b1;
                end else begin
                    e.trap   = 1'b1;
                    m_halted = 1'b1;
                end
            end else begin
                if (rt) m_retries = 0;
                if (m_waiting) begin
                    if (ma) begin
                        m_waiting = 1'b0;
                    end else begin
                        e.stall  = 4'b1111;
                        e.flush  = 4'b1000;
                        m_waited = m_waited + 1;
                    end
                end else if (mr && !ma) begin
                    e.stall   = 4'b1111;
                    e.flush   = 4'b1000;
                    m_waiting = 1'b1;
                    m_waited  = 0;
                end else if (bt) begin
                    e.flush = 4'b0011;
                end else if (li) begin
                    e.stall = 4'b0011;
                    e.flush = 4'b0010;
                end
            end
        end
        if (e.stall != 4'b0000) m_stalls++;
        if (e.flush != 4'b0000) m_flushes++;
    endtask

    // Apply one cycle of inputs, queue the model's answer, advance to the next cycle.
    task automatic cycle(input bit rst, input bit li, input bit bt, input bit mr,
                         input bit ma, input bit f, input bit rt);
        exp_t e;
        reset          = rst;
        load_use_i     = li;
        branch_taken_i = bt;
        mem_req_i      = mr;
        mem_ack_i      = ma;
        fault_i        = f;
        retire_i       = rt;
        model_step(rst, li, bt, mr, ma, f, rt, e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation on each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("stall",  {60'd0, stall_m, stall_e, stall_d, stall_f}, {60'd0, e.stall});
                check("flush",  {60'd0, flush_w, flush_m, flush_e, flush_d}, {60'd0, e.flush});
                check("replay", {63'd0, replay_o}, {63'd0, e.replay});
                check("trap",   {63'd0, trap_o},   {63'd0, e.trap});
                check("busy",   {63'd0, busy_o},   {63'd0, e.busy});
                if (e.known) begin
                    check("retry_cnt",    {{(64-RC_W){1'b0}}, retry_cnt_o}, 64'(e.retry));
                    check("stall_cycles", {{(64-CNT_W){1'b0}}, stall_cycles_o}, 64'(e.scnt));
                    check("flush_events", {{(64-CNT_W){1'b0}}, flush_events_o}, 64'(e.fcnt));
                end
                cyc++;
            end
        end
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        @(posedge clk);
        #1;
        // Reset held for two cycles, then idle in RUN.
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Branch overrides load-use; then load-use alone inserts a bubble.
        cycle(0, 1, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        idle(1);
        // Single-cycle access (req and ack together) does not stall.
        cycle(0, 0, 0, 1, 1, 0, 0);
        // Access acknowledged three cycles after the request.
        cycle(0, 0, 0, 1, 0, 0, 0);
        cycle(0, 1, 1, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 1, 0, 0);
        idle(1);
        // No ack at all: timeout takes the replay path.
        cycle(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < MEM_TIMEOUT + 2; i++) cycle(0, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1);
        // Fault arriving together with an ack in MEMWAIT.
        cycle(0, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 1, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 1);
        // Three replays, then a fourth fault traps; HALT ignores everything.
        for (int i = 0; i < RETRY_MAX; i++) begin
            cycle(0, 0, 0, 0, 0, 1, 0);
            cycle(0, 0, 0, 0, 0, 1, 0);
        end
        cycle(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 1, 1, 0, 1, 1);
        cycle(1, 0, 0, 0, 0, 0, 0);
        idle(1);
        // fault, retire, fault: count goes 1, 0, 1; fault with retire still increments.
        cycle(0, 0, 0, 0, 0, 1, 0);
        idle(1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1, 0);
        idle(1);
        cycle(0, 0, 0, 0, 0, 1, 1);
        idle(2);
        // Counter scenario: five load-use stalls and two branch flushes after reset.
        cycle(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0, 0);
        idle(2);
        // Randomized traffic with occasional faults and resets.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 24) == 0),
                  1'($urandom_range(0, 3) == 0));
        end
        idle(2);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_seq_ctrl.md
Name: pipe_seq_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. Drives the enable (stall) and synchronous-clear (flush) inputs of the F/D/E/M/W pipeline registers. Resolves load-use, taken-branch, multi-cycle data-memory wait, and fault-replay events. Includes a retry/trap FSM for the fault-tolerant pipeline variant.

Parameters:
RETRY_MAX, 3, max consecutive replays of one faulting instruction before trap
MEM_TIMEOUT, 16, cycles in MEMWAIT without ack before a timeout fault (>=2)
CNT_W, 32, width of optional performance counters

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
load_use_i  in  1  D-stage source depends on E-stage load
branch_taken_i  in  1  taken branch/jump resolved in E
mem_req_i  in  1  M stage issuing data access this cycle
mem_ack_i  in  1  data memory completes access
fault_i  in  1  fault detected on instruction entering W
retire_i  in  1  instruction commits in W without fault
stall_f, stall_d, stall_e, stall_m  out  1 each  hold register (enable = ~stall)
flush_d, flush_e, flush_m, flush_w  out  1 each  drive register synchronous clear
replay_o  out  1  one-cycle pulse: redirect PC to faulting instruction PC
trap_o  out  1  one-cycle pulse: fatal fault, enter halt
busy_o  out  1  state != RUN
retry_cnt_o  out  $clog2(RETRY_MAX+1)  current retry count
stall_cycles_o, flush_events_o  out  CNT_W  performance counters (see Optional Feature)

Behaviour:
- States: RUN, MEMWAIT, REPLAY, HALT. Registered state, wait timer, and retry_cnt. Control outputs are combinational from state and inputs, with zero-cycle latency to the pipeline registers.
- Reset (sync): state=RUN, timer=0, retry_cnt=0. While reset=1: all stalls 0, all flushes 1, replay_o=0, trap_o=0, busy_o=0.
- RUN priority: fault_i > (mem_req_i & ~mem_ack_i) > branch_taken_i > load_use_i.
  - fault_i, retry_cnt<RETRY_MAX: flush_d/e/m/w=1, replay_o=1, retry_cnt++, go to REPLAY.
  - fault_i, retry_cnt==RETRY_MAX: flush all, trap_o=1, go to HALT.
  - mem_req_i & ~mem_ack_i: stall_f/d/e/m=1, flush_w=1, timer=0, go to MEMWAIT.
  - mem_req_i & mem_ack_i in the same cycle: no stall; single-cycle access.
  - branch_taken_i: flush_d=1, flush_e=1; no stall. Overrides a simultaneous load_use_i (stall suppressed).
  - load_use_i only: stall_f=1, stall_d=1, flush_e=1 (one bubble).
- MEMWAIT:
  - Every cycle: stall_f/d/e/m=1, flush_w=1, timer++.
  - mem_ack_i: stalls released that same cycle, flush_w=0, go to RUN.
  - timer==MEM_TIMEOUT-1 without ack: treated as fault_i, using the RUN fault path (replay or trap).
  - fault_i beats mem_ack_i in the same cycle.
  - branch_taken_i and load_use_i are ignored.
- REPLAY: exactly one cycle. flush_d/e/m=1, no stalls, then RUN. fault_i in this cycle is ignored (pipe is empty).
- retire_i clears retry_cnt to 0 unless fault_i is also high that cycle; fault wins.
- HALT: all stalls 1, all flushes 1, busy_o=1. Stays until reset; all inputs are ignored.
- retry_cnt never exceeds RETRY_MAX. Timer saturates and never wraps.

Optional Feature:
PIPE_PERF_CNT_EN.
- Defined: stall_cycles_o counts cycles with any stall_* high. flush_events_o counts cycles with any flush_* high, excluding reset. Both are saturating at all-ones and cleared by reset.
- Undefined: both ports are tied to 0 and no counter flops are inferred.

Decomposition:
- Package pipe_ctrl_pkg: seq_state_e enum (RUN, MEMWAIT, REPLAY, HALT), stage-index constants, and a ctrl_t struct bundling the 4 stall + 4 flush bits.
- Sub-module sat_counter #(WIDTH) (clk, reset, clr, inc, q). Used for the MEMWAIT timer and both performance counters.

Test Plan:
- Reset held 2 cycles -> flush_d..w=1, stalls=0; after release, state RUN, retry_cnt_o=0, busy_o=0.
- load_use_i=1 and branch_taken_i=1 in the same cycle -> flush_d=flush_e=1, stall_f=stall_d=0. Next cycle load_use_i only -> stall_f=stall_d=flush_e=1.
- mem_req_i=1, ack after 3 cycles -> stall_f..m=1 and flush_w=1 for 3 cycles, released in the ack cycle. With no ack, at cycle 16 -> replay_o pulse, retry_cnt_o=1.
- fault_i on 3 consecutive retries, then a 4th -> replay_o pulses 3 times, retry_cnt_o 1,2,3, then trap_o pulse, HALT with all stalls/flushes=1 until reset.
- fault_i, then retire_i, then fault_i -> retry_cnt_o goes 1, 0, 1. fault_i and retire_i together -> count increments.
- PIPE_PERF_CNT_EN defined, 5 stall cycles + 2 branch flushes -> stall_cycles_o=5, flush_events_o=2. Undefined -> both read 0.
